// File: rtl/mux_scan_ctrl.sv
// Select-line sequencer for a 4:1 mux: scans channels 0..3, samples the mux output
// after a settle time on each channel, and hands the 4-bit frame over valid/ready.
module mux_scan_ctrl #(
  parameter int SETTLE = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       run,
  output logic       s0,
  output logic       s1,
  input  logic       mux_in,
  output logic [3:0] frame,
  output logic       frame_valid,
  input  logic       frame_ready,
  output logic       busy
);

  if (SETTLE < 1 || SETTLE > 255) begin : g_bad_settle
    $error("mux_scan_ctrl: SETTLE must be in 1..255");
  end

  localparam logic [7:0] RELOAD = 8'(SETTLE - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    OUT  = 2'd2
  } state_t;

  state_t     state;
  logic [1:0] sel;
  logic [7:0] cnt;

  // Selects come straight from a register so the mux never sees a glitch.
  assign s0 = sel[0];
  assign s1 = sel[1];

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      sel         <= 2'd0;
      cnt         <= 8'd0;
      frame       <= 4'd0;
      frame_valid <= 1'b0;
      busy        <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          sel <= 2'd0;
          if (run) begin
            state <= WAIT;
            cnt   <= RELOAD;
            busy  <= 1'b1;
          end
        end

        WAIT: begin
          if (cnt != 8'd0) begin
            cnt <= cnt - 8'd1;
          end else begin
            frame[sel] <= mux_in;
            if (sel != 2'd3) begin
              sel <= sel + 2'd1;
              cnt <= RELOAD;
            end else begin
              // Last channel sampled: hold sel at 3 and present the frame.
              state       <= OUT;
              frame_valid <= 1'b1;
            end
          end
        end

        OUT: begin
          if (frame_ready) begin
            frame_valid <= 1'b0;
            sel         <= 2'd0;
            if (run) begin
              state <= WAIT;
              cnt   <= RELOAD;
            end else begin
              state <= IDLE;
              busy  <= 1'b0;
            end
          end
        end

        default: begin
          state       <= IDLE;
          sel         <= 2'd0;
          frame_valid <= 1'b0;
          busy        <= 1'b0;
        end
      endcase
    end
  end

endmodule
